// File: rtl/regfile_mp.sv
// regfile_mp - parametrised multi-port general-purpose register file.
//
// Sits between decode (reads) and writeback (writes). Two write ports
// (port 1 has priority on an address collision), NRD independent read ports
// with one cycle of latency and same-cycle write bypass, and a per-register
// pending (scoreboard) bit. After reset an init sweep writes zero to every
// entry before the file reports ready.
//
// Ports:
//   clk                   clock
//   rst                   synchronous, active-low reset
//   we0/waddr0/wdata0     write port 0
//   we1/waddr1/wdata1     write port 1 (wins on same-address collision)
//   set_pend/pend_addr    mark a register pending (producer issued)
//   re[NRD]               per-port read enable
//   raddr[NRD*ADDR_W]     read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata[NRD*DATA_W]     registered read data, port k at [k*DATA_W +: DATA_W]
//   rpend[NRD]            registered pending flag of the operand read
//   ready                 1 = init sweep finished, file usable
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    set_pend,
  input  logic [ADDR_W-1:0]       pend_addr,
  input  logic [NRD-1:0]          re,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic [NRD-1:0]          rpend,
  output logic                    ready
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  // An address is usable if it exists and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < DEPTH_A);
    if ((ZERO_REG != 0) && (a == '0)) ok = 1'b0;
    return ok;
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend_reg, pend_next;
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              run;
  logic              wr0, wr1, setp;

  assign run   = (state_reg == ST_RUN);
  assign ready = run;

  // Qualified write / set strobes: only in RUN and only to usable entries.
  assign wr0  = run & we0 & addr_ok(waddr0);
  assign wr1  = run & we1 & addr_ok(waddr1);
  assign setp = run & set_pend & addr_ok(pend_addr);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // ------------------------------------------------------ register array
  // Storage is deliberately not reset: the init sweep zeroes one entry per
  // cycle. Port 1 is written after port 0 so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        regs[cnt_reg] <= '0;
      end else begin
        if (wr0) regs[waddr0] <= wdata0;
        if (wr1) regs[waddr1] <= wdata1;
      end
    end
  end

  // ---------------------------------------------------------- scoreboard
  // Writebacks clear, then a new issue sets: a producer issued in the same
  // cycle as the old value's writeback keeps the register pending.
  always_comb begin
    pend_next = pend_reg;
    if (!run) begin
      pend_next = '0;
    end else begin
      if (wr0)  pend_next[waddr0]    = 1'b0;
      if (wr1)  pend_next[waddr1]    = 1'b0;
      if (setp) pend_next[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_reg <= '0;
    else      pend_reg <= pend_next;
  end

  // ---------------------------------------------------------- read ports
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_reg, rd_next;
      logic              rp_reg, rp_next;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      // Bypass order mirrors write priority so the read sees exactly the
      // value the array will hold after this edge; pending is likewise
      // taken after this cycle's set/clear.
      always_comb begin
        rd_next = '0;
        rp_next = 1'b0;
        if (run && re[gi] && addr_ok(ra)) begin
          if (wr1 && (waddr1 == ra))      rd_next = wdata1;
          else if (wr0 && (waddr0 == ra)) rd_next = wdata0;
          else                            rd_next = regs[ra];
          rp_next = pend_next[ra];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_reg <= '0;
          rp_reg <= 1'b0;
        end else begin
          rd_reg <= rd_next;
          rp_reg <= rp_next;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd_reg;
      assign rpend[gi]                  = rp_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (default 32x32 with 2 read ports,
// and DEPTH=24 with 4 read ports) driven with the same write/scoreboard
// stimulus, checked every cycle against a behavioural model, plus a vector
// table and hand-written multi-cycle sequences.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we0, we1, set_pend;
  logic [4:0]  waddr0, waddr1, pend_addr;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  re;
  logic [19:0] raddr;

  logic [63:0]  rdata_a;
  logic [1:0]   rpend_a;
  logic         ready_a;
  logic [127:0] rdata_b;
  logic [3:0]   rpend_b;
  logic         ready_b;

  int checks;
  int failures;

  regfile_mp dut_a (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .set_pend(set_pend), .pend_addr(pend_addr),
    .re(re[1:0]), .raddr(raddr[9:0]),
    .rdata(rdata_a), .rpend(rpend_a), .ready(ready_a)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NRD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .set_pend(set_pend), .pend_addr(pend_addr),
    .re(re), .raddr(raddr),
    .rdata(rdata_b), .rpend(rpend_b), .ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------ behavioural model
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];
  int          m_n    [2];      // RUN-edges since release, saturating at depth
  logic [31:0] exp_rd [2][4];
  bit          exp_rp [2][4];
  bit          exp_ready [2];

  function automatic int dep(int i);
    return (i == 0) ? 32 : 24;
  endfunction

  function automatic int nrd(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic bit m_ok(int i, int a);
    return (a != 0) && (a < dep(i));
  endfunction

  // Called right after a rising edge with the inputs that edge sampled.
  // Reads return the post-write contents, which is what bypass means.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_rd[i][k] = 32'h0;
        exp_rp[i][k] = 1'b0;
      end
      if (!rst) begin
        m_n[i] = 0;
        for (int j = 0; j < 32; j++) m_pend[i][j] = 1'b0;
        exp_ready[i] = 1'b0;
      end else if (m_n[i] < dep(i)) begin
        m_n[i]++;
        if (m_n[i] == dep(i))
          for (int j = 0; j < 32; j++) m_regs[i][j] = 32'h0;
        exp_ready[i] = (m_n[i] == dep(i));
      end else begin
        if (we0 && m_ok(i, int'(waddr0))) begin
          m_regs[i][waddr0] = wdata0;
          m_pend[i][waddr0] = 1'b0;
        end
        if (we1 && m_ok(i, int'(waddr1))) begin
          m_regs[i][waddr1] = wdata1;
          m_pend[i][waddr1] = 1'b0;
        end
        if (set_pend && m_ok(i, int'(pend_addr))) m_pend[i][pend_addr] = 1'b1;
        for (int k = 0; k < nrd(i); k++) begin
          int a;
          a = int'(raddr[k*5 +: 5]);
          if (re[k] && m_ok(i, a)) begin
            exp_rd[i][k] = m_regs[i][a];
            exp_rp[i][k] = m_pend[i][a];
          end
        end
        exp_ready[i] = 1'b1;
      end
    end
  endtask

  // ------------------------------------------------------------ checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("model_ready_a", 32'(ready_a), 32'(exp_ready[0]));
    check("model_ready_b", 32'(ready_b), 32'(exp_ready[1]));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_a_rdata%0d", k), rdata_a[k*32 +: 32], exp_rd[0][k]);
      check($sformatf("model_a_rpend%0d", k), 32'(rpend_a[k]), 32'(exp_rp[0][k]));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model_b_rdata%0d", k), rdata_b[k*32 +: 32], exp_rd[1][k]);
      check($sformatf("model_b_rpend%0d", k), 32'(rpend_b[k]), 32'(exp_rp[1][k]));
    end
  endtask

  // One clock: inputs already driven (at the previous negedge); model
  // follows the edge; outputs compared at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_idle();
    we0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
    we1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
    set_pend = 1'b0; pend_addr = 5'd0;
    re = 4'h0; raddr = 20'h0;
  endtask

  task automatic set_ra(input int k, input int a);
    raddr[k*5 +: 5] = 5'(a);
  endtask

  // Counts clock edges after release until ready_a rises (bounded).
  task automatic wait_ready(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      if (ready_b && nb == 0) nb = c;
      if (ready_a) begin
        na = c;
        break;
      end
    end
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  // ------------------------------------------------------ vector table
  typedef struct {
    logic        we0;  logic [4:0] wa0; logic [31:0] wd0;
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
    logic        sp;   logic [4:0] pa;
    logic [1:0]  re;   logic [4:0] ra0; logic [4:0]  ra1;
    logic [31:0] rd0;  logic [31:0] rd1;
    logic        rp0;  logic        rp1;
  } vec_t;

  function automatic vec_t mkv(int we0_i, int wa0_i, logic [31:0] wd0_i,
                               int we1_i, int wa1_i, logic [31:0] wd1_i,
                               int sp_i, int pa_i, int re_i, int ra0_i, int ra1_i,
                               logic [31:0] rd0_i, logic [31:0] rd1_i, int rp0_i, int rp1_i);
    vec_t v;
    v.we0 = 1'(we0_i); v.wa0 = 5'(wa0_i); v.wd0 = wd0_i;
    v.we1 = 1'(we1_i); v.wa1 = 5'(wa1_i); v.wd1 = wd1_i;
    v.sp  = 1'(sp_i);  v.pa  = 5'(pa_i);
    v.re  = 2'(re_i);  v.ra0 = 5'(ra0_i); v.ra1 = 5'(ra1_i);
    v.rd0 = rd0_i;     v.rd1 = rd1_i;
    v.rp0 = 1'(rp0_i); v.rp1 = 1'(rp1_i);
    return v;
  endfunction

  vec_t tv [14];

  initial begin
    int na, nb;
    checks   = 0;
    failures = 0;

    //            we0 wa0 wd0           we1 wa1 wd1    sp pa re ra0 ra1 rd0           rd1     rp0 rp1
    tv[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,        32'h0,  0, 0);
    tv[1]  = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1, 5, 0, 32'hDEADBEEF, 32'h0,  0, 0);
    tv[2]  = mkv(1, 0, 32'h1234,     0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,        32'h0,  0, 0);
    tv[3]  = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0,        32'h0,  0, 0);
    tv[4]  = mkv(1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 3, 5, 7, 32'hDEADBEEF, 32'h22, 0, 0);
    tv[5]  = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 3, 7, 7, 32'h22,       32'h22, 0, 0);
    tv[6]  = mkv(0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 1, 9, 0, 32'h0,        32'h0,  1, 0);
    tv[7]  = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 2, 0, 9, 32'h0,        32'h0,  0, 1);
    tv[8]  = mkv(1, 9, 32'hAB,       0, 0, 32'h0,  0, 0, 3, 9, 9, 32'hAB,       32'hAB, 0, 0);
    tv[9]  = mkv(0, 0, 32'h0,        1, 9, 32'hCD, 1, 9, 1, 9, 0, 32'hCD,       32'h0,  1, 0);
    tv[10] = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 3, 9, 9, 32'hCD,       32'hCD, 1, 1);
    tv[11] = mkv(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 5, 7, 32'h0,        32'h0,  0, 0);
    tv[12] = mkv(0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 1, 0, 0, 32'h0,        32'h0,  0, 0);
    tv[13] = mkv(1, 5, 32'h77,       1, 31, 32'h99, 0, 0, 3, 5, 9, 32'h77,      32'hCD, 0, 1);

    drive_idle();
    rst = 1'b0;

    // --- Init: reset two cycles, then count edges until ready
    cycle();
    cycle();
    check("reset_ready", 32'(ready_a), 32'h0);
    check("reset_rdata0", rdata_a[31:0], 32'h0);
    rst = 1'b1;
    wait_ready(na, nb);
    check("init_len_a", 32'(na), 32'd32);
    check("init_len_b", 32'(nb), 32'd24);
    re = 4'b0011; set_ra(0, 17); set_ra(1, 31);
    cycle();
    check("init_zero_rd0", rdata_a[31:0], 32'h0);
    check("init_zero_rd1", rdata_a[63:32], 32'h0);
    check("init_zero_rp", 32'(rpend_a), 32'h0);
    drive_idle();

    // --- Table-driven directed vectors on the 32-deep instance
    for (int n = 0; n < 14; n++) begin
      we0 = tv[n].we0; waddr0 = tv[n].wa0; wdata0 = tv[n].wd0;
      we1 = tv[n].we1; waddr1 = tv[n].wa1; wdata1 = tv[n].wd1;
      set_pend = tv[n].sp; pend_addr = tv[n].pa;
      re = {2'b00, tv[n].re};
      raddr = 20'h0;
      set_ra(0, int'(tv[n].ra0));
      set_ra(1, int'(tv[n].ra1));
      cycle();
      check($sformatf("vec%0d_rd0", n), rdata_a[31:0], tv[n].rd0);
      check($sformatf("vec%0d_rd1", n), rdata_a[63:32], tv[n].rd1);
      check($sformatf("vec%0d_rp0", n), 32'(rpend_a[0]), 32'(tv[n].rp0));
      check($sformatf("vec%0d_rp1", n), 32'(rpend_a[1]), 32'(tv[n].rp1));
    end
    drive_idle();

    // --- Reset in RUN with register 3 pending
    set_pend = 1'b1; pend_addr = 5'd3;
    cycle();
    drive_idle();
    re = 4'b0001; set_ra(0, 3);
    cycle();
    check("run_pend3", 32'(rpend_a[0]), 32'h1);
    drive_idle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_ready(na, nb);
    check("rerun_len_a", 32'(na), 32'd32);
    re = 4'b0001; set_ra(0, 3);
    cycle();
    check("rerun_rd3", rdata_a[31:0], 32'h0);
    check("rerun_rp3", 32'(rpend_a[0]), 32'h0);
    drive_idle();

    // --- Reset asserted at cycle 10 of INIT
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    check("midinit_ready", 32'(ready_a), 32'h0);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_ready(na, nb);
    check("midinit_len_a", 32'(na), 32'd32);
    check("midinit_len_b", 32'(nb), 32'd24);

    // --- DEPTH=24 / 4-port instance: out-of-range write, simultaneous reads
    we0 = 1'b1; waddr0 = 5'd30; wdata0 = 32'h5555;
    we1 = 1'b1; waddr1 = 5'd23; wdata1 = 32'h2323;
    cycle();
    we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h0101;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h0202;
    cycle();
    drive_idle();
    re = 4'b1111; set_ra(0, 1); set_ra(1, 2); set_ra(2, 1); set_ra(3, 23);
    cycle();
    check("b4_port0", rdata_b[31:0],   32'h0101);
    check("b4_port1", rdata_b[63:32],  32'h0202);
    check("b4_port2", rdata_b[95:64],  32'h0101);
    check("b4_port3", rdata_b[127:96], 32'h2323);
    drive_idle();
    re = 4'b0001; set_ra(0, 30);
    cycle();
    check("b_oob_rd30", rdata_b[31:0], 32'h0);
    check("b_oob_rp30", 32'(rpend_b[0]), 32'h0);
    check("a_rd30", rdata_a[31:0], 32'h5555);
    drive_idle();

    // --- Randomised traffic with occasional resets, checked by the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) != 0);
      we0       = 1'($urandom_range(0, 1));
      waddr0    = rand_addr();
      wdata0    = $urandom;
      we1       = 1'($urandom_range(0, 1));
      waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : rand_addr();
      wdata1    = $urandom;
      set_pend  = ($urandom_range(0, 2) == 0);
      pend_addr = rand_addr();
      re        = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) set_ra(k, int'(rand_addr()));
      cycle();
    end
    drive_idle();
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
